fft_frame_streamer: RTL

//  Frame-building AXI-stream transmitter feeding the FFT input port. Collects windowed
//  8-bit samples from hanning_window into a ping-pong buffer. Streams each completed

---
 rtl/fft_frame_streamer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fft_frame_streamer.sv
// Ping-pong frame buffer between the window stage and the FFT input: collects FRAME_LEN
// samples per bank, then streams the bank out as an AXI-stream frame with tlast.
module fft_frame_streamer #(
    parameter int FRAME_LEN    = 1024,
    parameter int SAMPLE_WIDTH = 8,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid_in,
    input  logic                    fft_ready_in,
    output logic [DATA_WIDTH-1:0]   fft_data_out,
    output logic                    fft_valid_out,
    output logic                    fft_last_out,
    output logic                    frame_drop_out,
    output logic                    busy_out
);
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    function automatic logic [DATA_WIDTH-1:0] to_word(input logic [SAMPLE_WIDTH-1:0] s);
        logic [15:0] re;
        re = 16'($signed(s));
        return {{(DATA_WIDTH-16){1'b0}}, re};
    endfunction

    logic [SAMPLE_WIDTH-1:0] bank_mem [2][FRAME_LEN];

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
    logic                    wr_bank_q, wr_bank_d;
    logic [1:0]              full_q, full_d;
    logic                    rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    drop_q, drop_d;
    logic                    busy_q, busy_d;

    logic                    rd_bank_sel;
    logic [IDX_W-1:0]        rd_addr;
    logic [SAMPLE_WIDTH-1:0] rd_sample;

    // Address of the next word to load into the output register: index 0 of the
    // full bank while idle (prefetch), otherwise the running read index.
    always_comb begin
        rd_bank_sel = (state_q == IDLE) ? full_q[1] : rd_bank_q;
        rd_addr     = (state_q == IDLE) ? '0 : rd_idx_q;
        rd_sample   = bank_mem[rd_bank_sel][rd_addr];
    end

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        full_d    = full_q;
        rd_bank_d = rd_bank_q;
        rd_idx_d  = rd_idx_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        drop_d    = 1'b0;

        if (sample_valid_in) begin
            wr_idx_d = wr_idx_q + 1'b1;
            if (wr_idx_q == LAST_IDX) begin
                wr_idx_d = '0;
                // Registered reader state decides: a frame finishing while the reader
                // is still streaming (even on its final beat) is discarded.
                if (state_q == IDLE) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                end else begin
                    drop_d = 1'b1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (|full_q) begin
                    state_d   = STREAM;
                    rd_bank_d = rd_bank_sel;
                    rd_idx_d  = IDX_W'(1);
                    data_d    = to_word(rd_sample);
                    valid_d   = 1'b1;
                    last_d    = 1'b0;
                end
            end
            STREAM: begin
                if (valid_q && fft_ready_in) begin
                    if (last_q) begin
                        state_d           = IDLE;
                        valid_d           = 1'b0;
                        last_d            = 1'b0;
                        full_d[rd_bank_q] = 1'b0;
                    end else begin
                        data_d   = to_word(rd_sample);
                        last_d   = (rd_idx_q == LAST_IDX);
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            wr_idx_q  <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
            rd_bank_q <= 1'b0;
            rd_idx_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            drop_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            rd_bank_q <= rd_bank_d;
            rd_idx_q  <= rd_idx_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            drop_q    <= drop_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (sample_valid_in) bank_mem[wr_bank_q][wr_idx_q] <= sample_in;
    end

    assign fft_data_out   = data_q;
    assign fft_valid_out  = valid_q;
    assign fft_last_out   = last_q;
    assign frame_drop_out = drop_q;
    assign busy_out       = busy_q;
endmodule
